unified_mem_ctrl: RTL and testbench

- Responder end of the CPU memory interface. Serves the CPU's instruction fetch port (pc, instr) and data port (address, re/we, write data, read data) from one single-ported backing memory with variable latency.
- Asserts freeze while any access is outstanding. Holds a one-entry instruction buffer so straight-line refetches need no backing access.
- Sits between the cpu top level and the backing memory model/SRAM wrapper.

---
 rtl/unified_mem_ctrl.sv | 111 +++++++++++
 tb/tb_unified_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - CPU instruction/data port responder sharing one single-ported backing memory
module unified_mem_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_addr,
    input  logic          i_re,
    output logic [DW-1:0] instr,
    input  logic [AW-1:0] d_addr,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] rd_data,
    output logic          freeze,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

    state_t        state;
    logic          ibuf_valid;
    logic [AW-1:0] ibuf_addr;
    logic [DW-1:0] ibuf_data;

    logic ibuf_hit;
    logic need_d;
    logic need_i;
    logic wr_inval;
    logic refetch;

    assign ibuf_hit = ibuf_valid & (ibuf_addr == i_addr);
    assign need_d   = d_re | d_we;
    assign need_i   = i_re & ~ibuf_hit;
    // A write landing on the buffered address makes the buffer stale, so the
    // follow-on fetch decision must see the hit as already gone.
    assign wr_inval = d_we & (d_addr == ibuf_addr);
    assign refetch  = i_re & ~(ibuf_hit & ~wr_inval);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ibuf_valid <= 1'b0;
            ibuf_addr  <= '0;
            ibuf_data  <= '0;
            rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_d)
                        state <= D_ACC;
                    else if (need_i)
                        state <= I_ACC;
                end
                D_ACC: begin
                    if (mem_rdy) begin
                        if (d_re)
                            rd_data <= mem_rdata;
                        if (wr_inval)
                            ibuf_valid <= 1'b0;
                        state <= refetch ? I_ACC : DONE;
                    end
                end
                I_ACC: begin
                    if (mem_rdy) begin
                        ibuf_addr  <= i_addr;
                        ibuf_data  <= mem_rdata;
                        ibuf_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Backing-side signals decode straight from the state register; the CPU
    // holds its inputs steady while frozen, so the addresses pass through.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        freeze    = 1'b0;
        case (state)
            IDLE: freeze = need_d | need_i;
            D_ACC: begin
                freeze    = 1'b1;
                mem_req   = 1'b1;
                mem_wr    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            I_ACC: begin
                freeze   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = i_addr;
            end
            default: freeze = 1'b0;
        endcase
    end

    assign instr = ibuf_data;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb/tb_unified_mem_ctrl.sv - randomized and directed bench for unified_mem_ctrl against a cache-level model
module tb_unified_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_addr;
    logic        i_re;
    logic [15:0] instr;
    logic [15:0] d_addr;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_wdata;
    logic [15:0] rd_data;
    logic        freeze;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    unified_mem_ctrl #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_re(i_re), .instr(instr),
        .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
        .rd_data(rd_data), .freeze(freeze), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // backing memory and responder state
    logic [15:0] mem [0:255];
    int          wait_cfg;
    int          wcnt;
    int          wtarget;
    bit          in_acc;
    logic [15:0] first_addr;
    bit          done_acc;
    bit          wr_now;
    logic [15:0] wa;
    logic [15:0] wd;

    // per-operation observations
    int          acc_cycles;
    int          frz_acc_cycles;
    int          frz_cycles;
    int          n_acc;
    bit          saw_wr;
    bit          drift;
    bit          consumed;
    logic [15:0] acc_addr [0:3];
    logic [15:0] got_instr;
    logic [15:0] got_rd;

    // reference model: memory contents, one-entry buffer, last read value
    logic [15:0] ref_mem [0:255];
    bit          rb_valid;
    logic [15:0] rb_addr;
    logic [15:0] ref_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        mem[a[7:0]] = v;
        ref_mem[a[7:0]] = v;
    endtask

    task automatic clear_stats();
        acc_cycles = 0; frz_acc_cycles = 0; frz_cycles = 0; n_acc = 0;
        saw_wr = 0; drift = 0; consumed = 0;
        for (int k = 0; k < 4; k++) acc_addr[k] = 16'hxxxx;
    endtask

    // one clock: sample settled outputs, play the memory, then take the edge
    task automatic tick();
        #2;
        if (freeze) frz_cycles++;
        else begin
            consumed  = 1;
            got_instr = instr;
            got_rd    = rd_data;
        end
        if (mem_req) begin
            if (!in_acc) begin
                in_acc = 1;
                wcnt = 0;
                first_addr = mem_addr;
                wtarget = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            acc_cycles++;
            if (freeze) frz_acc_cycles++;
            if (mem_addr !== first_addr) drift = 1;
            if (wcnt == wtarget) begin
                mem_rdy = 1'b1;
                mem_rdata = mem_wr ? 16'hDEAD : mem[mem_addr[7:0]];
            end else begin
                mem_rdy = 1'b0;
                mem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            mem_rdy = 1'b0;
        end
        done_acc = mem_req && mem_rdy;
        wr_now   = done_acc && mem_wr;
        wa = mem_addr;
        wd = mem_wdata;
        @(posedge clk);
        if (done_acc) begin
            if (n_acc < 4) acc_addr[n_acc] = wa;
            if (wr_now) begin
                mem[wa[7:0]] = wd;
                saw_wr = 1;
            end
            n_acc++;
            in_acc = 0;
        end
        #1;
    endtask

    task automatic op(input string tag, input logic [15:0] ia, input bit dre, input bit dwe,
                      input logic [15:0] da, input logic [15:0] dwd);
        int exp_acc;
        i_addr = ia; d_re = dre; d_we = dwe; d_addr = da; d_wdata = dwd;
        clear_stats();
        for (int c = 0; c < 60 && !consumed; c++) tick();
        chk({tag, "_consumed"}, 32'(consumed), 32'd1);
        exp_acc = (dre || dwe) ? 1 : 0;
        if (dwe) begin
            ref_mem[da[7:0]] = dwd;
            if (rb_valid && rb_addr == da) rb_valid = 0;
        end
        if (dre) ref_rd = ref_mem[da[7:0]];
        if (!(rb_valid && rb_addr == ia)) begin
            exp_acc++;
            rb_valid = 1;
            rb_addr = ia;
        end
        chk({tag, "_instr"}, 32'(got_instr), 32'(ref_mem[ia[7:0]]));
        chk({tag, "_rd"}, 32'(got_rd), 32'(ref_rd));
        chk({tag, "_naccess"}, 32'(n_acc), 32'(exp_acc));
        d_re = 0; d_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) set_mem(16'(k), 16'($urandom));
        rb_valid = 0; rb_addr = 0; ref_rd = 0;
        in_acc = 0; wait_cfg = 0;
        mem_rdy = 0; mem_rdata = 0;
        i_addr = 0; i_re = 1; d_addr = 0; d_re = 0; d_we = 0; d_wdata = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freeze", 32'(freeze), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        i_re = 0;
        #1;
        chk("rst_freeze_idle", 32'(freeze), 32'd0);
        i_re = 1;
        rst_n = 1;
        @(posedge clk);
        #1;

        // first fetch miss, zero-wait, then a buffer hit
        set_mem(16'h0000, 16'hA123);
        wait_cfg = 0;
        op("t1_miss", 16'h0000, 0, 0, 16'h0, 16'h0);
        chk("t1_acc_cycles", 32'(acc_cycles), 32'd1);
        chk("t1_frz_acc", 32'(frz_acc_cycles), 32'd1);
        op("t1_hit", 16'h0000, 0, 0, 16'h0, 16'h0);
        chk("t1_hit_frz", 32'(frz_cycles), 32'd0);
        chk("t1_hit_req", 32'(acc_cycles), 32'd0);

        // fetch miss with three wait states
        wait_cfg = 3;
        op("t2", 16'h0020, 0, 0, 16'h0, 16'h0);
        chk("t2_acc_cycles", 32'(acc_cycles), 32'd4);
        chk("t2_frz_acc", 32'(frz_acc_cycles), 32'd4);
        chk("t2_addr", 32'(acc_addr[0]), 32'h0020);
        chk("t2_drift", 32'(drift), 32'd0);

        // data read plus fetch miss: data first
        wait_cfg = 0;
        set_mem(16'h0040, 16'h5555);
        set_mem(16'h0002, 16'h7777);
        op("t3", 16'h0002, 1, 0, 16'h0040, 16'h0);
        chk("t3_first_addr", 32'(acc_addr[0]), 32'h0040);
        chk("t3_second_addr", 32'(acc_addr[1]), 32'h0002);

        // write to the buffered address forces a refetch
        op("t4_fill", 16'h0010, 0, 0, 16'h0, 16'h0);
        op("t4_wr", 16'h0010, 0, 1, 16'h0010, 16'hBEEF);
        chk("t4_mem_wr", 32'(saw_wr), 32'd1);
        chk("t4_wr_addr", 32'(acc_addr[0]), 32'h0010);
        chk("t4_refetch_addr", 32'(acc_addr[1]), 32'h0010);

        // reset in the middle of a data access
        wait_cfg = 10;
        i_addr = 16'h0010; d_re = 1; d_we = 0; d_addr = 16'h0050;
        clear_stats();
        tick();
        tick();
        chk("t5_in_dacc", 32'(mem_req), 32'd1);
        rst_n = 0;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_freeze", 32'(freeze), 32'd1);
        mem_rdy = 1; mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1;
        mem_rdy = 0; d_re = 0; in_acc = 0;
        rst_n = 1;
        #1;
        chk("t5_rd_zero", 32'(rd_data), 32'd0);
        chk("t5_idle_req", 32'(mem_req), 32'd0);
        rb_valid = 0; ref_rd = 0;

        // write-only with buffer hit, one wait state
        wait_cfg = 1;
        op("t6_fill", 16'h0030, 0, 0, 16'h0, 16'h0);
        op("t6_wr", 16'h0030, 0, 1, 16'h0031, 16'h1234);
        chk("t6_acc_cycles", 32'(acc_cycles), 32'd2);
        chk("t6_frz_acc", 32'(frz_acc_cycles), 32'd2);
        chk("t6_mem_wr", 32'(saw_wr), 32'd1);

        // randomized traffic with random wait states
        wait_cfg = -1;
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [15:0] ia;
            logic [15:0] da;
            kind = int'($urandom_range(0, 2));
            ia = 16'($urandom_range(0, 7));
            da = 16'($urandom_range(0, 15));
            op("rnd", ia, kind == 1, kind == 2, da, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
